// File: rtl/qarma_key_ctrl.sv
// QARMA key-schedule controller: latches the master key, derives w1/k1 once, then
// sequences the 2R+3 whitening/round/reflect keys to the datapath over a valid/ready handshake.
module qarma_key_ctrl #(
  parameter int N = 128,
  parameter int R = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*N-1:0]       key,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic                 start_valid,
  output logic                 start_ready,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [2:0]           step_kind,
  output logic [$clog2(R)-1:0] round_idx,
  output logic [N-1:0]         rk,
  output logic                 busy,
  output logic                 done
);

  localparam int SW = $clog2(2*R+3);
  localparam int IW = $clog2(R);
  localparam logic [SW-1:0] FWD_END = SW'(R);
  localparam logic [SW-1:0] REFL    = SW'(R+1);
  localparam logic [SW-1:0] BWD_END = SW'(2*R+1);
  localparam logic [SW-1:0] LAST    = SW'(2*R+2);

  typedef enum logic [1:0] {IDLE, SPEC, RUN, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   step_cnt;
  logic [SW-1:0]   nxt_step;
  logic            key_loaded;
  logic [N-1:0]    w0, k0, w1, k1;
  logic [2:0]      nxt_kind;
  logic [IW-1:0]   nxt_idx;
  logic [N-1:0]    nxt_rk;
  logic            key_hs, start_hs;

  assign key_ready   = (state == IDLE);
  assign start_ready = (state == IDLE) && key_loaded && !key_valid;
  assign key_hs      = key_ready && key_valid;
  assign start_hs    = start_ready && start_valid;

  // Decode the step about to be presented so the outputs can be registered directly.
  always_comb begin
    nxt_step = (state == RUN) ? step_cnt + SW'(1) : '0;
    nxt_kind = 3'd0;
    nxt_idx  = '0;
    nxt_rk   = w0;
    if (nxt_step == '0) begin
      nxt_kind = 3'd0;
      nxt_rk   = w0;
    end else if (nxt_step <= FWD_END) begin
      nxt_kind = 3'd1;
      nxt_idx  = IW'(nxt_step - SW'(1));
      nxt_rk   = k0;
    end else if (nxt_step == REFL) begin
      nxt_kind = 3'd2;
      nxt_rk   = k1;
    end else if (nxt_step <= BWD_END) begin
      nxt_kind = 3'd3;
      nxt_idx  = IW'(BWD_END - nxt_step);
      nxt_rk   = k1;
    end else begin
      nxt_kind = 3'd4;
      nxt_rk   = w1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step_cnt   <= '0;
      key_loaded <= 1'b0;
      w0         <= '0;
      k0         <= '0;
      w1         <= '0;
      k1         <= '0;
      rk_valid   <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      rk         <= '0;
      step_kind  <= 3'd0;
      round_idx  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_hs) begin
            w0    <= key[2*N-1:N];
            k0    <= key[N-1:0];
            state <= SPEC;
          end else if (start_hs) begin
            state     <= RUN;
            step_cnt  <= '0;
            busy      <= 1'b1;
            rk_valid  <= 1'b1;
            step_kind <= nxt_kind;
            round_idx <= nxt_idx;
            rk        <= nxt_rk;
          end
        end
        SPEC: begin
          // w1 = w0 rotated right by one with the new LSB xored with the old MSB.
          w1         <= {w0[0], w0[N-1:2], w0[1] ^ w0[N-1]};
          k1         <= k0;
          key_loaded <= 1'b1;
          state      <= IDLE;
        end
        RUN: begin
          if (rk_valid && rk_ready) begin
            if (step_cnt == LAST) begin
              state    <= DONE;
              rk_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              step_cnt  <= nxt_step;
              step_kind <= nxt_kind;
              round_idx <= nxt_idx;
              rk        <= nxt_rk;
            end
          end
        end
        DONE: begin
          busy     <= 1'b0;
          step_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qarma_key_ctrl.sv
// Bench for qarma_key_ctrl: control-handshake vector table, then whole schedules compared
// against a step list derived from the key-schedule rules, under several rk_ready patterns.
module tb_qarma_key_ctrl;
  localparam int N  = 128;
  localparam int R  = 11;
  localparam int IW = $clog2(R);
  localparam int NS = 2*R+3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2*N-1:0] key;
  logic           key_valid, key_ready, start_valid, start_ready;
  logic           rk_valid, rk_ready, busy, done;
  logic [2:0]     step_kind;
  logic [IW-1:0]  round_idx;
  logic [N-1:0]   rk;

  qarma_key_ctrl #(.N(N), .R(R)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .key_ready(key_ready),
    .start_valid(start_valid), .start_ready(start_ready), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .step_kind(step_kind), .round_idx(round_idx), .rk(rk),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    kind;
    logic [IW-1:0] idx;
    logic [N-1:0]  rkv;
  } step_t;

  typedef struct {
    logic           kv, sv;
    logic [2*N-1:0] k;
    logic           e_kr, e_sr, e_rkv, e_busy;
  } vec_t;

  int nvec = 0;
  int nmis = 0;
  step_t expv [NS];
  logic [N-1:0] mw0, mk0, mw1, mk1;

  localparam logic [2*N-1:0] KA = {128'h0123456789ABCDEF0123456789ABCDEF,
                                   128'hFEDCBA9876543210FEDCBA9876543210};
  localparam logic [2*N-1:0] KB = {128'h00112233445566778899AABBCCDDEEFF,
                                   128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0};

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    nvec++;
    nmis++;
    $display("FAIL %s: cycle budget expired at %0t", name, $time);
  endtask

  // Expected schedule, built straight from the step rules.
  task automatic set_model(input logic [2*N-1:0] kk);
    mw0 = kk[2*N-1:N];
    mk0 = kk[N-1:0];
    mw1 = {mw0[0], mw0[N-1:1]} ^ {{(N-1){1'b0}}, mw0[N-1]};
    mk1 = mk0;
    for (int i = 0; i < NS; i++) begin
      if (i == 0)              begin expv[i].kind = 3'd0; expv[i].idx = '0;             expv[i].rkv = mw0; end
      else if (i <= R)         begin expv[i].kind = 3'd1; expv[i].idx = IW'(i - 1);     expv[i].rkv = mk0; end
      else if (i == R + 1)     begin expv[i].kind = 3'd2; expv[i].idx = '0;             expv[i].rkv = mk1; end
      else if (i <= 2*R + 1)   begin expv[i].kind = 3'd3; expv[i].idx = IW'(2*R+1 - i); expv[i].rkv = mk1; end
      else                     begin expv[i].kind = 3'd4; expv[i].idx = '0;             expv[i].rkv = mw1; end
    end
  endtask

  function automatic logic [2*N-1:0] rand_key();
    logic [2*N-1:0] r = '0;
    for (int i = 0; i < 2*N/32; i++) r = {r[2*N-33:0], $urandom()};
    return r;
  endfunction

  task automatic load_key(input logic [2*N-1:0] kk);
    @(negedge clk);
    key = kk; key_valid = 1'b1;
    #1 chk("load_kr", N'(key_ready), N'(1'b1));
    @(negedge clk);
    key_valid = 1'b0;
    #1 chk("spec_kr", N'(key_ready), N'(1'b0));
    chk("spec_sr", N'(start_ready), N'(1'b0));
    set_model(kk);
  endtask

  task automatic start_sched();
    @(negedge clk);
    start_valid = 1'b1;
    #1 chk("start_rdy", N'(start_ready), N'(1'b1));
  endtask

  // mode 0: rk_ready=1, 1: pattern 1,0,0,1, 2: random. Returns in the done cycle.
  task automatic collect(input int mode, input logic keep);
    step_t got[$];
    logic pv = 1'b0, pr = 1'b0;
    step_t ps;
    bit seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      start_valid = keep;
      rk_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 4 == 0) || (c % 4 == 3))
                                                  : 1'($urandom_range(0, 1));
      #1;
      if (c == 0) chk("first_valid", N'(rk_valid), N'(1'b1));
      chk("busy_run", N'(busy), N'(1'b1));
      chk("kr_run", N'(key_ready), N'(1'b0));
      if (pv && !pr) begin
        chk("hold_vld", N'(rk_valid), N'(1'b1));
        chk("hold_kind", N'(step_kind), N'(ps.kind));
        chk("hold_idx", N'(round_idx), N'(ps.idx));
        chk("hold_rk", rk, ps.rkv);
      end
      if (done) begin
        chk("done_rkv", N'(rk_valid), N'(1'b0));
        chk("done_after_last", N'({pv && pr, got.size() == NS}), N'(2'b11));
        seen = 1'b1;
      end
      if (rk_valid && rk_ready) got.push_back('{step_kind, round_idx, rk});
      pv = rk_valid; pr = rk_ready;
      ps = '{step_kind, round_idx, rk};
    end
    if (!seen) timeout("sched_done");
    chk("step_count", N'(got.size()), N'(NS));
    for (int i = 0; i < got.size() && i < NS; i++) begin
      chk($sformatf("kind[%0d]", i), N'(got[i].kind), N'(expv[i].kind));
      chk($sformatf("idx[%0d]", i), N'(got[i].idx), N'(expv[i].idx));
      chk($sformatf("rk[%0d]", i), got[i].rkv, expv[i].rkv);
    end
  endtask

  task automatic post_done();
    @(negedge clk);
    #1 chk("done_1cyc", N'(done), N'(1'b0));
    chk("busy_idle", N'(busy), N'(1'b0));
    chk("kr_idle", N'(key_ready), N'(1'b1));
  endtask

  vec_t tbl [16];

  initial begin
    rst_n = 1'b0; key = '0; key_valid = 1'b0; start_valid = 1'b0; rk_ready = 1'b0;
    for (int i = 0; i < 10; i++) tbl[i] = '{1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, KB, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, KA, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, '0, 1'b1, 1'b1, 1'b0, 1'b0};

    #12;
    chk("rst_kr", N'(key_ready), N'(1'b1));
    chk("rst_sr", N'(start_ready), N'(1'b0));
    chk("rst_rkv", N'(rk_valid), N'(1'b0));
    chk("rst_done", N'(done), N'(1'b0));
    chk("rst_busy", N'(busy), N'(1'b0));
    chk("rst_rk", rk, '0);
    chk("rst_kind", N'(step_kind), N'(3'd0));
    chk("rst_idx", N'(round_idx), N'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // No-key start attempts, key load, simultaneous key+start, then a start in row 15.
    set_model(KA);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      key_valid = tbl[i].kv; start_valid = tbl[i].sv; key = tbl[i].k; rk_ready = 1'b1;
      #1;
      chk($sformatf("tbl%0d_kr", i), N'(key_ready), N'(tbl[i].e_kr));
      chk($sformatf("tbl%0d_sr", i), N'(start_ready), N'(tbl[i].e_sr));
      chk($sformatf("tbl%0d_rkv", i), N'(rk_valid), N'(tbl[i].e_rkv));
      chk($sformatf("tbl%0d_busy", i), N'(busy), N'(tbl[i].e_busy));
    end
    collect(0, 1'b0);
    post_done();

    start_sched();
    collect(1, 1'b0);
    post_done();

    // Back-to-back with start_valid held high.
    start_sched();
    collect(0, 1'b1);
    @(negedge clk);
    #1 chk("b2b_sr", N'(start_ready), N'(1'b1));
    chk("b2b_done", N'(done), N'(1'b0));
    collect(0, 1'b1);
    start_valid = 1'b0;
    post_done();

    // Reset at step 7.
    begin
      int n = 0;
      bit hit = 1'b0;
      start_sched();
      for (int c = 0; c < 60 && !hit; c++) begin
        @(negedge clk);
        start_valid = 1'b0; rk_ready = 1'b1;
        #1;
        if (rk_valid && n == 7) begin
          chk("s7_kind", N'(step_kind), N'(3'd1));
          chk("s7_idx", N'(round_idx), N'(6));
          rst_n = 1'b0;
          #1;
          chk("mr_rkv", N'(rk_valid), N'(1'b0));
          chk("mr_done", N'(done), N'(1'b0));
          chk("mr_busy", N'(busy), N'(1'b0));
          chk("mr_rk", rk, '0);
          chk("mr_kind", N'(step_kind), N'(3'd0));
          chk("mr_idx", N'(round_idx), N'(0));
          chk("mr_kr", N'(key_ready), N'(1'b1));
          chk("mr_sr", N'(start_ready), N'(1'b0));
          hit = 1'b1;
        end else if (rk_valid && rk_ready) n++;
      end
      if (!hit) timeout("reach_step7");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        start_valid = 1'b1;
        #1 chk("nokey_sr", N'(start_ready), N'(1'b0));
        chk("nokey_rkv", N'(rk_valid), N'(1'b0));
        chk("nokey_done", N'(done), N'(1'b0));
      end
      start_valid = 1'b0;
    end

    // Random keys with random backpressure; some schedules reuse the held key.
    for (int it = 0; it < 5; it++) begin
      if (it == 0 || $urandom_range(0, 1) == 1) load_key(rand_key());
      start_sched();
      collect(2, 1'b0);
      post_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
